// File: rtl/servo_pkg.sv
// Shared servo PWM constants, position codes and decoder FSM states.
// Both the PWM generator and the decoder import this so pulse widths never drift apart.
package servo_pkg;

  localparam int CONTA_1MS     = 50_000;
  localparam int CONTA_15MS    = 75_000;
  localparam int CONTA_2MS     = 100_000;
  localparam int CONTA_PERIODO = 1_000_000;

  localparam logic [1:0] POS_NENHUM = 2'b00;
  localparam logic [1:0] POS_1MS    = 2'b01;
  localparam logic [1:0] POS_15MS   = 2'b10;
  localparam logic [1:0] POS_2MS    = 2'b11;

  typedef enum logic [1:0] {
    INICIAL = 2'b00,
    ESPERA  = 2'b01,
    ALTO    = 2'b10,
    ESTOURO = 2'b11
  } estado_t;

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer for the asynchronous PWM line plus a third flop for edge detection.
// armado rises once the pipeline holds real samples instead of reset zeros.
module sincroniza_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic sync,
  output logic sub,
  output logic desc,
  output logic armado
);

  logic [2:0] pipe_reg;
  logic [1:0] carga_reg;
  logic       prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_reg  <= '0;
      carga_reg <= '0;
    end else begin
      pipe_reg  <= {pipe_reg[1:0], entrada};
      carga_reg <= {carga_reg[0], 1'b1};
    end
  end

  assign sync   = pipe_reg[1];
  assign prev   = pipe_reg[2];
  assign sub    = sync & ~prev;
  assign desc   = ~sync & prev;
  // The reset zeros in the pipeline are not a real low level; wait until they are flushed.
  assign armado = carga_reg[1];

endmodule

// File: rtl/decodificador_servo.sv
// Servo PWM receiver: measures each high pulse in clocks, classifies it into a 2-bit
// position, and reports "no pulse" (00) after a low-time timeout.
module decodificador_servo
  import servo_pkg::*;
#(
  parameter int CONTA_1MS_P    = CONTA_1MS,
  parameter int CONTA_15MS_P   = CONTA_15MS,
  parameter int CONTA_2MS_P    = CONTA_2MS,
  parameter int TOLERANCIA     = 2_500,
  parameter int CONTA_MAX_ALTO = 150_000,
  parameter int TIMEOUT        = 2_000_000,
  parameter int N              = 21
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         controle,
  output logic [1:0]   posicao,
  output logic [N-1:0] largura,
  output logic         pronto,
  output logic         erro,
  output logic [1:0]   db_estado
);

  localparam logic [N-1:0] LO_1MS     = N'(CONTA_1MS_P - TOLERANCIA);
  localparam logic [N-1:0] HI_1MS     = N'(CONTA_1MS_P + TOLERANCIA);
  localparam logic [N-1:0] LO_15MS    = N'(CONTA_15MS_P - TOLERANCIA);
  localparam logic [N-1:0] HI_15MS    = N'(CONTA_15MS_P + TOLERANCIA);
  localparam logic [N-1:0] LO_2MS     = N'(CONTA_2MS_P - TOLERANCIA);
  localparam logic [N-1:0] HI_2MS     = N'(CONTA_2MS_P + TOLERANCIA);
  localparam logic [N-1:0] MAX_ALTO   = N'(CONTA_MAX_ALTO);
  localparam logic [N-1:0] TIMEOUT_M1 = N'(TIMEOUT - 1);
  localparam logic [N-1:0] UM         = {{(N-1){1'b0}}, 1'b1};

  logic sync, sub, desc, armado;

  estado_t      estado_reg, estado_next;
  logic [N-1:0] contador_reg, contador_next;
  logic [N-1:0] largura_reg, largura_next;
  logic [1:0]   posicao_reg, posicao_next;
  logic         pronto_reg, pronto_next;
  logic         erro_reg, erro_next;
  logic         em_1ms, em_15ms, em_2ms, timeout_ok, estouro_ok;

  sincroniza_borda u_sincroniza_borda (
    .clock   (clock),
    .reset   (reset),
    .entrada (controle),
    .sync    (sync),
    .sub     (sub),
    .desc    (desc),
    .armado  (armado)
  );

  assign em_1ms     = (contador_reg >= LO_1MS)  && (contador_reg <= HI_1MS);
  assign em_15ms    = (contador_reg >= LO_15MS) && (contador_reg <= HI_15MS);
  assign em_2ms     = (contador_reg >= LO_2MS)  && (contador_reg <= HI_2MS);
  assign timeout_ok = contador_reg >= TIMEOUT_M1;
  assign estouro_ok = contador_reg >= MAX_ALTO;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg   <= INICIAL;
      contador_reg <= '0;
      largura_reg  <= '0;
      posicao_reg  <= POS_NENHUM;
      pronto_reg   <= 1'b0;
      erro_reg     <= 1'b0;
    end else begin
      estado_reg   <= estado_next;
      contador_reg <= contador_next;
      largura_reg  <= largura_next;
      posicao_reg  <= posicao_next;
      pronto_reg   <= pronto_next;
      erro_reg     <= erro_next;
    end
  end

  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      INICIAL: if (armado && !sync) estado_next = ESPERA;
      ESPERA:  if (sub) estado_next = ALTO;
      ALTO: begin
        if (desc)            estado_next = ESPERA;
        else if (estouro_ok) estado_next = ESTOURO;
      end
      ESTOURO: if (!sync) estado_next = ESPERA;
      default: estado_next = INICIAL;
    endcase
  end

  always_comb begin
    contador_next = contador_reg;
    largura_next  = largura_reg;
    posicao_next  = posicao_reg;
    erro_next     = erro_reg;
    pronto_next   = 1'b0;
    case (estado_reg)
      INICIAL: if (armado && !sync) contador_next = '0;
      ESPERA: begin
        // A rising edge beats a timeout that lands on the same cycle.
        if (sub) begin
          contador_next = UM;
        end else if (timeout_ok) begin
          contador_next = '0;
          pronto_next   = 1'b1;
          posicao_next  = POS_NENHUM;
          largura_next  = '0;
          erro_next     = 1'b0;
        end else begin
          contador_next = contador_reg + UM;
        end
      end
      ALTO: begin
        if (desc) begin
          contador_next = '0;
          pronto_next   = 1'b1;
          largura_next  = contador_reg;
          erro_next     = 1'b0;
          if (em_1ms)       posicao_next = POS_1MS;
          else if (em_15ms) posicao_next = POS_15MS;
          else if (em_2ms)  posicao_next = POS_2MS;
          else              erro_next    = 1'b1;
        end else if (estouro_ok) begin
          pronto_next  = 1'b1;
          erro_next    = 1'b1;
          largura_next = MAX_ALTO;
        end else if (sync) begin
          contador_next = contador_reg + UM;
        end
      end
      ESTOURO: if (!sync) contador_next = '0;
      default: contador_next = '0;
    endcase
  end

  assign posicao   = posicao_reg;
  assign largura   = largura_reg;
  assign pronto    = pronto_reg;
  assign erro      = erro_reg;
  assign db_estado = estado_reg;

endmodule

// File: tb/tb_decodificador_servo.sv
// Randomized scoreboard bench for decodificador_servo with scaled-down timing constants.
// Stimulus tasks push expected reports; a negedge monitor pops and compares on each pronto.
module tb_decodificador_servo;

  localparam int C1   = 100;
  localparam int C15  = 150;
  localparam int C2   = 200;
  localparam int TOL  = 5;
  localparam int MAXA = 300;
  localparam int TO   = 4000;
  localparam int PER  = 2000;
  localparam int N    = 21;
  localparam int SLACK = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         controle = 1'b0;
  logic [1:0]   posicao;
  logic [N-1:0] largura;
  logic         pronto;
  logic         erro;
  logic [1:0]   db_estado;

  decodificador_servo #(
    .CONTA_1MS_P    (C1),
    .CONTA_15MS_P   (C15),
    .CONTA_2MS_P    (C2),
    .TOLERANCIA     (TOL),
    .CONTA_MAX_ALTO (MAXA),
    .TIMEOUT        (TO),
    .N              (N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .controle  (controle),
    .posicao   (posicao),
    .largura   (largura),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] pos;
    int         larg;
    logic       err;
    int         t;
  } rep_t;

  rep_t fila[$];
  int   tests = 0;
  int   fails = 0;
  logic [1:0] ult_pos = 2'b00;
  int   t_ref = 0;
  logic pronto_ant = 1'b0;

  // Reference classification: distance from each nominal width, inclusive tolerance.
  function automatic int classe(input int w);
    int d1, d15, d2;
    d1  = (w > C1)  ? w - C1  : C1 - w;
    d15 = (w > C15) ? w - C15 : C15 - w;
    d2  = (w > C2)  ? w - C2  : C2 - w;
    if (d1 <= TOL)  return 1;
    if (d15 <= TOL) return 2;
    if (d2 <= TOL)  return 3;
    return -1;
  endfunction

  task automatic push(input logic [1:0] p, input int l, input logic e, input int t);
    rep_t r;
    r.pos = p; r.larg = l; r.err = e; r.t = t;
    fila.push_back(r);
  endtask

  // Monitor: every pronto must match the oldest expected report, on time.
  always @(negedge clock) begin
    rep_t e;
    if (!reset) begin
      if (pronto) begin
        if (pronto_ant) begin
          tests++; fails++;
          $display("FAIL pronto_width: pronto high two cycles at cyc=%0d, required one", cyc);
        end
        tests++;
        if (fila.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pronto: cyc=%0d pos=%0d larg=%0d erro=%0d, required no report",
                   cyc, posicao, largura, erro);
        end else begin
          e = fila.pop_front();
          if (posicao !== e.pos || int'(largura) != e.larg || erro !== e.err ||
              cyc < e.t - SLACK || cyc > e.t + SLACK) begin
            fails++;
            $display("FAIL report: got pos=%0d larg=%0d erro=%0d cyc=%0d, required pos=%0d larg=%0d erro=%0d cyc=%0d",
                     posicao, largura, erro, cyc, e.pos, e.larg, e.err, e.t);
          end else begin
            $display("[TB] report ok pos=%0d larg=%0d erro=%0d cyc=%0d", posicao, largura, erro, cyc);
          end
        end
      end else if (fila.size() > 0 && cyc > fila[0].t + SLACK) begin
        e = fila.pop_front();
        tests++; fails++;
        $display("FAIL missing_report: none by cyc=%0d, required pos=%0d larg=%0d erro=%0d at cyc=%0d",
                 cyc, e.pos, e.larg, e.err, e.t);
      end
    end
    pronto_ant <= pronto;
  end

  task automatic nivel(input logic v, input int n);
    controle = v;
    repeat (n) @(negedge clock);
  endtask

  // Low for L cycles; any timeout whose deadline precedes the next rising edge is expected.
  task automatic idle(input int l);
    int c;
    c = cyc;
    while (t_ref + TO < c + l + 3) begin
      t_ref += TO;
      push(2'b00, 0, 1'b0, t_ref);
      ult_pos = 2'b00;
    end
    nivel(1'b0, l);
  endtask

  task automatic pulso(input int w);
    int c, k;
    c = cyc;
    if (w > MAXA) begin
      push(ult_pos, MAXA, 1'b1, c + MAXA + 3);
    end else begin
      k = classe(w);
      if (k < 0) begin
        push(ult_pos, w, 1'b1, c + w + 3);
      end else begin
        ult_pos = 2'(k);
        push(ult_pos, w, 1'b0, c + w + 3);
      end
    end
    nivel(1'b1, w);
    t_ref = cyc + 3;
  endtask

  task automatic check_reset(input string nome);
    tests++;
    if (posicao !== 2'b00 || largura !== '0 || pronto !== 1'b0 || erro !== 1'b0 || db_estado !== 2'b00) begin
      fails++;
      $display("FAIL %s: pos=%0d larg=%0d pronto=%0d erro=%0d estado=%0d, required all zero",
               nome, posicao, largura, pronto, erro, db_estado);
    end else begin
      $display("[TB] %s ok", nome);
    end
  endtask

  initial begin
    int w, r;
    @(negedge clock);
    repeat (4) @(negedge clock);
    check_reset("reset_state");
    reset = 1'b0;
    t_ref = cyc + 3;
    ult_pos = 2'b00;

    // Idle line: two timeout reports.
    idle(2 * TO + TO / 8);

    // Each nominal position for several periods.
    for (int p = 0; p < 3; p++) begin
      w = (p == 0) ? C1 : (p == 1) ? C15 : C2;
      for (int i = 0; i < 4; i++) begin
        pulso(w);
        idle(PER - w);
      end
    end

    // Window boundaries.
    pulso(C1 + TOL);     idle(500);
    pulso(C1 + TOL + 1); idle(500);
    pulso(C1 - TOL);     idle(500);
    pulso(C1 - TOL - 1); idle(500);
    pulso(C15 + TOL);    idle(500);
    pulso(C2 - TOL);     idle(500);

    // High too long: overflow report, silent exit, then a valid pulse.
    pulso(2 * MAXA); idle(500);
    pulso(MAXA);     idle(500);
    pulso(MAXA + 1); idle(500);
    pulso(C15);      idle(500);

    // Reset while high: truncated pulse never reported.
    controle = 1'b1;
    repeat (40) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset("reset_mid_pulse");
    fila.delete();
    reset = 1'b0;
    ult_pos = 2'b00;
    nivel(1'b1, 50);
    t_ref = cyc + 3;
    idle(300);
    pulso(C2); idle(500);

    // Randomized pulses.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: w = C1  + $urandom_range(0, 2 * TOL + 4) - TOL - 2;
        1: w = C15 + $urandom_range(0, 2 * TOL + 4) - TOL - 2;
        2: w = C2  + $urandom_range(0, 2 * TOL + 4) - TOL - 2;
        3: w = MAXA + $urandom_range(0, 4) - 2;
        4: w = $urandom_range(1, MAXA + 20);
        default: w = $urandom_range(1, 10);
      endcase
      pulso(w);
      idle($urandom_range(30, PER));
    end

    // Position 11 then the line goes quiet: one timeout back to 00.
    for (int i = 0; i < 3; i++) begin
      pulso(C2);
      idle(PER - C2);
    end
    idle(TO + 200);
    repeat (10) @(negedge clock);

    tests++;
    if (fila.size() != 0) begin
      fails++;
      $display("FAIL pending_reports: %0d left, required 0", fila.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decodificador_servo.md
Name: decodificador_servo

Overview:
- Receiver end of the servo PWM link: samples the `controle` waveform produced by controle_servo and recovers the commanded 2-bit position.
- Measures each high pulse in clock cycles, classifies it as 1 ms, 1.5 ms or 2 ms, and detects "no pulse" (position 00) by timeout.
- Used for closed-loop checking on the board (FPGA loopback of `controle`) and as a self-checking monitor in benches.

Parameters:
- CONTA_1MS, 50_000, clocks in a 1.0 ms pulse (50 MHz).
- CONTA_15MS, 75_000, clocks in a 1.5 ms pulse.
- CONTA_2MS, 100_000, clocks in a 2.0 ms pulse.
- TOLERANCIA, 2_500, accepted ± deviation in clocks (50 µs).
- CONTA_MAX_ALTO, 150_000, high-time limit (3 ms) before overflow.
- TIMEOUT, 2_000_000, low-time limit (40 ms = 2 PWM periods) meaning "no pulse".
- N, 21, counter and `largura` width; must hold TIMEOUT.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- controle  in  1  asynchronous PWM input.
- posicao  out  2  last decoded position; 00 means no pulse.
- largura  out  N  last measured high time in clocks; 0 after a timeout.
- pronto  out  1  one-cycle strobe; posicao/largura/erro updated this cycle.
- erro  out  1  last event was an invalid pulse (out of all windows, or overflow).
- db_estado  out  2  FSM state code, for debug.

Behaviour:
- Reset is synchronous and active-high. All outputs are registered.
- Reset values: posicao=00, largura=0, pronto=0, erro=0, counter=0, state=INICIAL, synchronizer flops=0.
- Reset mid-pulse discards the measurement. No pronto is issued.
- Input path:
  - 2-flop synchronizer, then a 3rd flop for edge detection.
  - `sub` = sync & ~prev. `desc` = ~sync & prev.
  - Input-to-edge latency is 3 clocks; widths are unaffected.
- FSM states and codes: INICIAL=00, ESPERA=01, ALTO=10, ESTOURO=11.
- INICIAL:
  - Wait until sync=0, then go to ESPERA with counter=0.
  - An input that is already high after reset is never measured as a partial pulse.
- ESPERA:
  - The counter increments every cycle.
  - On `sub`: counter←1, go to ALTO.
  - If the counter reaches TIMEOUT-1 without `sub`: pronto=1 next cycle, posicao←00, largura←0, erro←0. Counter←0, stay in ESPERA, so one report is issued every 40 ms while the line is idle.
  - If `sub` and the timeout occur in the same cycle, `sub` wins.
- ALTO:
  - The counter increments while sync=1, so largura equals the exact number of high cycles.
  - On `desc`: largura←counter, pronto=1 next cycle, classify, counter←0, go to ESPERA.
  - If the counter reaches CONTA_MAX_ALTO: pronto=1, erro←1, largura←CONTA_MAX_ALTO, posicao unchanged, go to ESTOURO.
- ESTOURO:
  - No measurement.
  - On sync=0: counter←0, go to ESPERA. No pronto on this exit.
- Classification (inclusive windows):
  - |w−CONTA_1MS| ≤ TOLERANCIA → 01.
  - |w−CONTA_15MS| ≤ TOLERANCIA → 10.
  - |w−CONTA_2MS| ≤ TOLERANCIA → 11.
  - In any window: erro←0.
  - Otherwise: erro←1, posicao unchanged.
  - Compare with unsigned range checks (lo ≤ w ≤ hi), not signed subtraction.
- pronto is exactly one cycle wide; erro and posicao hold until the next pronto.
- A glitch shorter than 3 clocks may be missed by the synchronizer; that is acceptable. Any detected short pulse classifies as erro.

Decomposition:
- Shared package/include `servo_pkg`:
  - The pulse constants CONTA_1MS, CONTA_15MS, CONTA_2MS and the 20 ms period (1_000_000).
  - Position codes POS_NENHUM=00, POS_1MS=01, POS_15MS=10, POS_2MS=11.
  - FSM state codes.
  - Used by both controle_servo and this block so they cannot drift apart.
- One natural sub-module: `sincroniza_borda` (2-flop synchronizer plus edge detector, outputs sync/sub/desc). The FSM, counter and classifier stay in the top module.

Test Plan:
1. Reset then idle low for 85 ms → pronto strobes at 40 ms and 80 ms (±3 clocks); posicao=00, largura=0, erro=0.
2. Loop back controle_servo with posicao 01, then 10, then 11, each for 100 ms → after the first full pulse of each: posicao=01/10/11, largura=50_000/75_000/100_000 exactly, erro=0, one pronto per 20 ms period.
3. Drive pulses of 52_500 and 52_501 clocks → 52_500 gives posicao=01 with erro=0; 52_501 gives erro=1 with posicao still 01, largura=52_501.
4. Hold input high for 200_000 clocks, then low → pronto with erro=1 and largura=150_000 at cycle 150_000 (+3); no second pronto at the falling edge; the next valid 1.5 ms pulse gives posicao=10, erro=0.
5. Assert reset while input is high mid-pulse, release, then let the pulse end → no pronto for the truncated pulse; the first pronto comes from the next complete pulse.
6. Switch controle_servo from 11 to 00 → last report posicao=11, then a timeout report with posicao=00 40 ms after the last rising edge region.
